shift_add_mult_ctrl: RTL

//  Sequencer that time-shares one WIDTH-bit ripple adder (same structure as the 32-bit full adder) to form an unsigned

---
 rtl/shift_add_mult_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add sequencer: one WIDTH-bit add per clock forms an unsigned 2*WIDTH product.
// Optional EARLY_TERM_EN macro: finish as soon as the remaining multiplier bits are all zero.
//   state  | meaning
//   IDLE   | waiting for start; product held
//   BUSY   | one add+shift iteration per edge
//   DONE   | one-cycle done pulse, product valid
module shift_add_mult_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   m, m_nxt;
    logic [WIDTH-1:0]   q, q_nxt;
    logic [2*WIDTH-1:0] p, p_nxt, p_iter;
    logic [2*WIDTH-1:0] product_nxt;
    logic [CW-1:0]      count, count_nxt;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;

    // Shared adder: carry-out lands in the MSB of the shifted partial product.
    always_comb begin
        addend = q[0] ? m : '0;
        sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        p_iter = {sum, p[WIDTH-1:1]};
    end

`ifdef EARLY_TERM_EN
    logic [CW:0] shamt;
    assign shamt = (CW+1)'(WIDTH) - {1'b0, count};
`endif

    always_comb begin
        state_nxt   = state;
        m_nxt       = m;
        q_nxt       = q;
        p_nxt       = p;
        count_nxt   = count;
        product_nxt = product;
        case (state)
            S_IDLE: begin
                if (start) begin
                    m_nxt     = a;
                    q_nxt     = b;
                    p_nxt     = '0;
                    count_nxt = '0;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
`ifdef EARLY_TERM_EN
                // No multiplier bits left: only the pending right shifts remain.
                if (q == '0) begin
                    product_nxt = p >> shamt;
                    state_nxt   = S_DONE;
                end else
`endif
                begin
                    p_nxt     = p_iter;
                    q_nxt     = q >> 1;
                    count_nxt = count + 1'b1;
                    if (count == CW'(WIDTH-1)) begin
                        product_nxt = p_iter;
                        state_nxt   = S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            m       <= '0;
            q       <= '0;
            p       <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state   <= state_nxt;
            m       <= m_nxt;
            q       <= q_nxt;
            p       <= p_nxt;
            count   <= count_nxt;
            product <= product_nxt;
        end
    end

    assign busy = (state == S_BUSY);
    assign done = (state == S_DONE);
endmodule
